// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg
// Shared definitions for the bit-serial subtractor slice: state encoding,
// default operand width and the bit-counter width helper.
// No ports (package).
package serial_sub_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    SHIFT = ST_SHIFT,
    DONE  = ST_DONE
  } state_e;

  // Bit counter must hold 0..width-1 and is never narrower than one bit.
  function automatic int cnt_width(input int width);
    int w;
    w = $clog2(width);
    if (w < 1) begin
      w = 1;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if
// Request/result bundle of the bit-serial subtractor.
//   start      : request, sampled only while the subtractor is not busy
//   a, b       : minuend / subtrahend (WIDTH bits)
//   borrow_in  : initial borrow
//   busy       : high while bits are being processed
//   done       : one-cycle completion pulse
//   diff       : (a - b - borrow_in) mod 2^WIDTH, held until the next completion
//   borrow_out : final borrow, 1 iff a < b + borrow_in
// Modports: master drives the request, slave is the subtractor.
interface serial_subtractor_if
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             borrow_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;

  modport master (
    output start, a, b, borrow_in,
    input  busy, done, diff, borrow_out
  );

  modport slave (
    input  start, a, b, borrow_in,
    output busy, done, diff, borrow_out
  );
endinterface

// File: rtl/full_subtractor_bit.sv
// full_subtractor_bit
// Purely combinational 1-bit full subtractor built from two half subtractors.
//   A, B       : minuend / subtrahend bit
//   borrow_in  : incoming borrow
//   diff       : A ^ B ^ borrow_in
//   borrow_out : borrow generated by either half stage
module full_subtractor_bit (
  input  logic A,
  input  logic B,
  input  logic borrow_in,
  output logic diff,
  output logic borrow_out
);

  logic hs1_diff_s;
  logic hs1_borrow_s;
  logic hs2_borrow_s;

  // First half subtractor: A - B.
  always_comb begin
    hs1_diff_s   = A ^ B;
    hs1_borrow_s = ~A & B;
  end

  // Second half subtractor: (A - B) - borrow_in, borrows merged.
  always_comb begin
    diff         = hs1_diff_s ^ borrow_in;
    hs2_borrow_s = ~hs1_diff_s & borrow_in;
    borrow_out   = hs1_borrow_s | hs2_borrow_s;
  end

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor
// Bit-serial unsigned subtractor: a - b - borrow_in over WIDTH bits, one bit
// per clock, LSB first. Owns the operand shift registers, the registered
// borrow chain and the sequencing; the per-bit arithmetic is a single shared
// full_subtractor_bit cell.
//   clk   : clock, all updates on the rising edge
//   rst_n : synchronous active-low reset
//   bus   : serial_subtractor_if slave (start/a/b/borrow_in in,
//           busy/done/diff/borrow_out out)
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_subtractor_if.slave  bus
);

  localparam int             CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  state_e           state_r;
  logic [WIDTH-1:0] sa_r;
  logic [WIDTH-1:0] sb_r;
  logic [WIDTH-1:0] part_r;
  logic [WIDTH-1:0] diff_r;
  logic [CW-1:0]    cnt_r;
  logic             br_r;
  logic             busy_r;
  logic             done_r;
  logic             bo_r;

  logic             d_s;
  logic             bo_s;
  logic [WIDTH-1:0] part_next_s;

  full_subtractor_bit u_cell (
    .A          (sa_r[0]),
    .B          (sb_r[0]),
    .borrow_in  (br_r),
    .diff       (d_s),
    .borrow_out (bo_s)
  );

  // Partial result after this cycle: new bit enters at the MSB, so after
  // WIDTH shifts bit 0 of the result sits in bit 0.
  always_comb begin
    part_next_s            = part_r >> 1;
    part_next_s[WIDTH-1]   = d_s;
  end

  // Sequencer, datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      sa_r    <= '0;
      sb_r    <= '0;
      part_r  <= '0;
      diff_r  <= '0;
      cnt_r   <= '0;
      br_r    <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      bo_r    <= 1'b0;
    end else begin
      case (state_r)
        // DONE shares IDLE's accept path so back-to-back requests have no gap.
        IDLE, DONE: begin
          if (bus.start) begin
            sa_r    <= bus.a;
            sb_r    <= bus.b;
            br_r    <= bus.borrow_in;
            cnt_r   <= '0;
            state_r <= SHIFT;
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
          end else begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
          end
        end
        SHIFT: begin
          sa_r   <= sa_r >> 1;
          sb_r   <= sb_r >> 1;
          part_r <= part_next_s;
          br_r   <= bo_s;
          cnt_r  <= cnt_r + 1'b1;
          if (cnt_r == CNT_LAST) begin
            // Result registers change only here, holding the old result
            // throughout a new operation.
            diff_r  <= part_next_s;
            bo_r    <= bo_s;
            state_r <= DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end else begin
            state_r <= SHIFT;
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.diff       = diff_r;
  assign bus.borrow_out = bo_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor
// Self-checking bench: three subtractor instances (WIDTH 1, 8, 13), each with
// a cycle-level expectation model derived from plain arithmetic, compared on
// every falling edge; directed hand-computed vectors plus a random regression.
module tb_serial_subtractor;

  logic clk;
  logic rst_n;
  logic cmp_en;
  int   checks;
  int   failures;

  logic [31:0] drv_a     [3];
  logic [31:0] drv_b     [3];
  logic        drv_bin   [3];
  logic        drv_start [3];

  logic [2:0][31:0] obs_diff;
  logic [2:0]       obs_bo;
  logic [2:0]       obs_busy;
  logic [2:0]       obs_done;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  for (genvar gi = 0; gi < 3; gi++) begin : g_w
    localparam int W = (gi == 0) ? 1 : ((gi == 1) ? 8 : 13);

    serial_subtractor_if #(.WIDTH(W)) bus ();

    assign bus.start     = drv_start[gi];
    assign bus.a         = drv_a[gi][W-1:0];
    assign bus.b         = drv_b[gi][W-1:0];
    assign bus.borrow_in = drv_bin[gi];

    assign obs_diff[gi] = 32'(bus.diff);
    assign obs_bo[gi]   = bus.borrow_out;
    assign obs_busy[gi] = bus.busy;
    assign obs_done[gi] = bus.done;

    serial_subtractor #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );

    // Expectation model: phase 0 idle, 1 working (m_k edges elapsed), 2 result
    // pulse. Result is plain modular arithmetic computed at acceptance.
    int           m_phase;
    int           m_k;
    logic [W-1:0] m_diff;
    logic [W-1:0] m_pend;
    logic         m_bo;
    logic         m_pbo;

    always @(posedge clk) begin
      if (!rst_n) begin
        m_phase <= 0;
        m_k     <= 0;
        m_diff  <= '0;
        m_bo    <= 1'b0;
      end else if (m_phase == 1) begin
        m_k <= m_k + 1;
        if (m_k + 1 == W) begin
          m_phase <= 2;
          m_diff  <= m_pend;
          m_bo    <= m_pbo;
        end
      end else if (drv_start[gi]) begin
        m_phase <= 1;
        m_k     <= 0;
        m_pend  <= W'(longint'(drv_a[gi][W-1:0]) - longint'(drv_b[gi][W-1:0])
                      - longint'(drv_bin[gi]));
        m_pbo   <= (longint'(drv_a[gi][W-1:0]) <
                    longint'(drv_b[gi][W-1:0]) + longint'(drv_bin[gi]));
      end else begin
        m_phase <= 0;
      end
    end

    always @(negedge clk) begin
      if (cmp_en) begin
        chk($sformatf("w%0d_busy", W), 32'(bus.busy), 32'(m_phase == 1));
        chk($sformatf("w%0d_done", W), 32'(bus.done), 32'(m_phase == 2));
        chk($sformatf("w%0d_diff", W), 32'(bus.diff), 32'(m_diff));
        chk($sformatf("w%0d_borrow_out", W), 32'(bus.borrow_out), 32'(m_bo));
      end
    end
  end

  // Drive a one-cycle start pulse; returns at the falling edge after acceptance.
  task automatic start_op(input int i, input logic [31:0] a, input logic [31:0] b,
                          input logic bin);
    @(negedge clk);
    drv_a[i]     = a;
    drv_b[i]     = b;
    drv_bin[i]   = bin;
    drv_start[i] = 1'b1;
    @(negedge clk);
    drv_start[i] = 1'b0;
  endtask

  // Wait (bounded) for done; counts busy cycles seen on the way.
  task automatic wait_done(input int i, output int bc);
    int n;
    bc = 0;
    n  = 0;
    while (obs_done[i] !== 1'b1 && n < 200) begin
      if (obs_busy[i] === 1'b1) bc++;
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 200) begin
      failures++;
      $display("FAIL done_timeout inst=%0d actual=no_done required=done", i);
    end
  endtask

  initial begin
    int bc;
    checks   = 0;
    failures = 0;
    cmp_en   = 1'b0;
    rst_n    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drv_a[i] = 32'd0; drv_b[i] = 32'd0; drv_bin[i] = 1'b0; drv_start[i] = 1'b0;
    end
    repeat (2) @(negedge clk);
    cmp_en = 1'b1;
    chk("reset_busy", 32'(obs_busy[1]), 32'd0);
    chk("reset_done", 32'(obs_done[1]), 32'd0);
    chk("reset_diff", obs_diff[1], 32'd0);
    chk("reset_bo",   32'(obs_bo[1]), 32'd0);
    rst_n = 1'b1;

    // 100 - 37
    start_op(1, 32'd100, 32'd37, 1'b0);
    wait_done(1, bc);
    chk("d_100_37_diff", obs_diff[1], 32'd63);
    chk("d_100_37_bo", 32'(obs_bo[1]), 32'd0);
    chk("d_100_37_busy_cycles", 32'(bc), 32'd8);

    // 5 - 9 wraps
    start_op(1, 32'd5, 32'd9, 1'b0);
    wait_done(1, bc);
    chk("d_5_9_diff", obs_diff[1], 32'd252);
    chk("d_5_9_bo", 32'(obs_bo[1]), 32'd1);

    // Reset in cycle 4 of an operation
    start_op(1, 32'd77, 32'd11, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_mid_busy", 32'(obs_busy[1]), 32'd0);
    chk("rst_mid_done", 32'(obs_done[1]), 32'd0);
    chk("rst_mid_diff", obs_diff[1], 32'd0);
    chk("rst_mid_bo", 32'(obs_bo[1]), 32'd0);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("rst_no_done", 32'(obs_done[1]), 32'd0);
    end
    start_op(1, 32'd10, 32'd3, 1'b0);
    wait_done(1, bc);
    chk("d_10_3_diff", obs_diff[1], 32'd7);
    chk("d_10_3_bo", 32'(obs_bo[1]), 32'd0);

    // 0 - 0 - 1 and 255 - 255
    start_op(1, 32'd0, 32'd0, 1'b1);
    wait_done(1, bc);
    chk("d_0_0_1_diff", obs_diff[1], 32'd255);
    chk("d_0_0_1_bo", 32'(obs_bo[1]), 32'd1);
    start_op(1, 32'd255, 32'd255, 1'b0);
    wait_done(1, bc);
    chk("d_255_255_diff", obs_diff[1], 32'd0);
    chk("d_255_255_bo", 32'(obs_bo[1]), 32'd0);

    // 200 - 50 with an ignored start during SHIFT, then back-to-back 7 - 7
    start_op(1, 32'd200, 32'd50, 1'b0);
    repeat (2) @(negedge clk);
    drv_a[1] = 32'd1; drv_b[1] = 32'd2; drv_bin[1] = 1'b1; drv_start[1] = 1'b1;
    @(negedge clk);
    drv_start[1] = 1'b0;
    wait_done(1, bc);
    chk("d_200_50_diff", obs_diff[1], 32'd150);
    chk("d_200_50_bo", 32'(obs_bo[1]), 32'd0);
    drv_a[1] = 32'd7; drv_b[1] = 32'd7; drv_bin[1] = 1'b0; drv_start[1] = 1'b1;
    @(negedge clk);
    drv_start[1] = 1'b0;
    chk("b2b_accept_busy", 32'(obs_busy[1]), 32'd1);
    chk("b2b_held_diff", obs_diff[1], 32'd150);
    wait_done(1, bc);
    chk("d_7_7_diff", obs_diff[1], 32'd0);
    chk("d_7_7_bo", 32'(obs_bo[1]), 32'd0);

    // Boundary widths
    start_op(0, 32'd0, 32'd1, 1'b0);
    wait_done(0, bc);
    chk("w1_0_1_diff", obs_diff[0], 32'd1);
    chk("w1_0_1_bo", 32'(obs_bo[0]), 32'd1);
    chk("w1_busy_cycles", 32'(bc), 32'd1);
    start_op(2, 32'd0, 32'd1, 1'b0);
    wait_done(2, bc);
    chk("w13_0_1_diff", obs_diff[2], 32'd8191);
    chk("w13_0_1_bo", 32'(obs_bo[2]), 32'd1);
    chk("w13_busy_cycles", 32'(bc), 32'd13);

    // Random regression: 1000 operations across the three widths
    for (int i = 0; i < 3; i++) begin
      for (int n = 0; n < ((i == 1) ? 400 : 300); n++) begin
        start_op(i, $urandom, $urandom, 1'($urandom_range(1, 0)));
        wait_done(i, bc);
      end
    end

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
